// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag controller for the endpoint data FIFO RAM.
// Build option: define FIFO_ERR_STICKY_EN for sticky error flags (default: one-cycle pulses).
module fifo_ptr_ctrl #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              store_tx_data,
  input  logic              store_rx_packet_data,
  input  logic              get_rx_data,
  input  logic              get_tx_packet_data,
  output logic [ADDR_W:0]   store_ptr,
  output logic [ADDR_W:0]   get_ptr,
  output logic [ADDR_W:0]   buffer_occupancy,
  output logic              full,
  output logic              empty,
  output logic              overflow_err,
  output logic              underflow_err
);

  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("fifo_ptr_ctrl: DEPTH must equal 2**ADDR_W");
  end

  logic              w_store_req;
  logic              w_get_req;
  logic              w_store_ok;
  logic              w_get_ok;
  logic              w_ovf_evt;
  logic              w_unf_evt;
  logic [ADDR_W:0]   w_store_ptr_nxt;
  logic [ADDR_W:0]   w_get_ptr_nxt;
  logic [ADDR_W:0]   w_occ_nxt;
  logic              w_full_nxt;
  logic              w_empty_nxt;
  logic              w_ovf_nxt;
  logic              w_unf_nxt;

  logic [ADDR_W:0]   r_store_ptr;
  logic [ADDR_W:0]   r_get_ptr;
  logic [ADDR_W:0]   r_occ;
  logic              r_full;
  logic              r_empty;
  logic              r_ovf;
  logic              r_unf;

  // Two sources on the same side share one FIFO slot per cycle.
  assign w_store_req = store_tx_data | store_rx_packet_data;
  assign w_get_req   = get_rx_data   | get_tx_packet_data;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_store_ok = 1'b0;
    w_get_ok   = 1'b0;
    w_ovf_evt  = 1'b0;
    w_unf_evt  = 1'b0;

    // A store at full is only legal when a get frees the slot in the same cycle.
    if (w_store_req) begin
      if (!r_full || w_get_req) w_store_ok = 1'b1;
      else                      w_ovf_evt  = 1'b1;
    end

    // A get at empty is never accepted, even alongside a store.
    if (w_get_req) begin
      if (!r_empty) w_get_ok  = 1'b1;
      else          w_unf_evt = 1'b1;
    end
  end

  // The extra MSB makes the pointers wrap naturally modulo 2*DEPTH.
  assign w_store_ptr_nxt = r_store_ptr + (ADDR_W+1)'(w_store_ok);
  assign w_get_ptr_nxt   = r_get_ptr   + (ADDR_W+1)'(w_get_ok);
  assign w_occ_nxt       = w_store_ptr_nxt - w_get_ptr_nxt;

  assign w_empty_nxt = (w_store_ptr_nxt == w_get_ptr_nxt);
  assign w_full_nxt  = (w_store_ptr_nxt[ADDR_W-1:0] == w_get_ptr_nxt[ADDR_W-1:0]) &&
                       (w_store_ptr_nxt[ADDR_W]     != w_get_ptr_nxt[ADDR_W]);

`ifdef FIFO_ERR_STICKY_EN
  // Errors latch until the host flushes the FIFO or reset.
  assign w_ovf_nxt = r_ovf | w_ovf_evt;
  assign w_unf_nxt = r_unf | w_unf_evt;
`else
  assign w_ovf_nxt = w_ovf_evt;
  assign w_unf_nxt = w_unf_evt;
`endif

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_store_ptr <= '0;
      r_get_ptr   <= '0;
      r_occ       <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else if (clear) begin
      // Flush wins over any strobe in the same cycle.
      r_store_ptr <= '0;
      r_get_ptr   <= '0;
      r_occ       <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_store_ptr <= w_store_ptr_nxt;
      r_get_ptr   <= w_get_ptr_nxt;
      r_occ       <= w_occ_nxt;
      r_full      <= w_full_nxt;
      r_empty     <= w_empty_nxt;
      r_ovf       <= w_ovf_nxt;
      r_unf       <= w_unf_nxt;
    end
  end

  assign store_ptr        = r_store_ptr;
  assign get_ptr          = r_get_ptr;
  assign buffer_occupancy = r_occ;
  assign full             = r_full;
  assign empty            = r_empty;
  assign overflow_err     = r_ovf;
  assign underflow_err    = r_unf;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: directed scenarios plus randomized traffic
// compared against a byte-count model of the FIFO.
module tb_fifo_ptr_ctrl;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int PW     = ADDR_W + 1;
  localparam int VW     = 3 * PW + 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          clear;
  logic          st_tx, st_rx, g_rx, g_tx;
  logic [PW-1:0] store_ptr, get_ptr, buffer_occupancy;
  logic          full, empty, overflow_err, underflow_err;

  int vectors     = 0;
  int miscompares = 0;

  // Model: total bytes ever accepted on each side since the last reset/clear.
  int unsigned m_wr, m_rd;
  logic        m_ovf, m_unf;

  logic [VW-1:0] obs_v, exp_vv;

  fifo_ptr_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .store_tx_data        (st_tx),
    .store_rx_packet_data (st_rx),
    .get_rx_data          (g_rx),
    .get_tx_packet_data   (g_tx),
    .store_ptr            (store_ptr),
    .get_ptr              (get_ptr),
    .buffer_occupancy     (buffer_occupancy),
    .full                 (full),
    .empty                (empty),
    .overflow_err         (overflow_err),
    .underflow_err        (underflow_err)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] obs();
    return {store_ptr, get_ptr, buffer_occupancy, full, empty, overflow_err, underflow_err};
  endfunction

  function automatic logic [VW-1:0] exp_v();
    int unsigned occ = m_wr - m_rd;
    logic [PW-1:0] sp = PW'(m_wr % (2 * DEPTH));
    logic [PW-1:0] gp = PW'(m_rd % (2 * DEPTH));
    logic [PW-1:0] op = PW'(occ);
    return {sp, gp, op, occ == DEPTH, occ == 0, m_ovf, m_unf};
  endfunction

  function automatic string fmt(input logic [VW-1:0] v);
    return $sformatf("sp=%0d gp=%0d occ=%0d full=%b empty=%b ovf=%b unf=%b",
                     v[VW-1 -: PW], v[VW-PW-1 -: PW], v[VW-2*PW-1 -: PW], v[3], v[2], v[1], v[0]);
  endfunction

  function automatic void model_reset();
    m_wr = 0; m_rd = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endfunction

  function automatic void model_step(input logic s_tx, s_rx, gr, gt, clr);
    int unsigned occ = m_wr - m_rd;
    logic s = s_tx | s_rx;
    logic g = gr | gt;
    logic ov_ev, un_ev;
    if (clr) begin
      model_reset();
      return;
    end
    ov_ev = s && (occ == DEPTH) && !g;
    un_ev = g && (occ == 0);
    if (s && (occ < DEPTH || g)) m_wr++;
    if (g && occ != 0)           m_rd++;
`ifdef FIFO_ERR_STICKY_EN
    m_ovf = m_ovf | ov_ev;
    m_unf = m_unf | un_ev;
`else
    m_ovf = ov_ev;
    m_unf = un_ev;
`endif
  endfunction

  // One clock cycle of stimulus; outputs are sampled 1 ns after the edge.
  task automatic drive(input logic s_tx, s_rx, gr, gt, clr);
    st_tx = s_tx; st_rx = s_rx; g_rx = gr; g_tx = gt; clear = clr;
    model_step(s_tx, s_rx, gr, gt, clr);
    @(posedge clk);
    #1;
    st_tx = 1'b0; st_rx = 1'b0; g_rx = 1'b0; g_tx = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] rst_v;
    rst_v = {PW'(0), PW'(0), PW'(0), 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Assert reset between edges: outputs must clear without a clock.
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    obs_v = obs();
    vectors++;
    if (obs_v !== rst_v) begin
      miscompares++;
      $display("FAIL reset_async: got %s expected %s", fmt(obs_v), fmt(rst_v));
    end
    st_tx = 1'b1; g_rx = 1'b1;
    @(posedge clk);
    #1;
    obs_v = obs();
    vectors++;
    if (obs_v !== rst_v) begin
      miscompares++;
      $display("FAIL reset_held: got %s expected %s", fmt(obs_v), fmt(rst_v));
    end
    st_tx = 1'b0; g_rx = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      obs_v = obs(); exp_vv = exp_v(); vectors++;
      if (obs_v !== exp_vv) begin
        miscompares++;
        $display("FAIL fill[%0d]: got %s expected %s", i, fmt(obs_v), fmt(exp_vv));
      end
    end
    vectors++;
    if (store_ptr !== PW'(DEPTH) || full !== 1'b1 || overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_overflow: got sp=%0d full=%b ovf=%b expected sp=64 full=1 ovf=1",
               store_ptr, full, overflow_err);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    obs_v = obs(); exp_vv = exp_v(); vectors++;
    if (obs_v !== exp_vv) begin
      miscompares++;
      $display("FAIL fill_after: got %s expected %s", fmt(obs_v), fmt(exp_vv));
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      obs_v = obs(); exp_vv = exp_v(); vectors++;
      if (obs_v !== exp_vv) begin
        miscompares++;
        $display("FAIL drain[%0d]: got %s expected %s", i, fmt(obs_v), fmt(exp_vv));
      end
    end
    vectors++;
    if (get_ptr !== PW'(DEPTH) || empty !== 1'b1 || underflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_underflow: got gp=%0d empty=%b unf=%b expected gp=64 empty=1 unf=1",
               get_ptr, empty, underflow_err);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    // Walk both pointers to 126 with the FIFO never going empty in between.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 125; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (store_ptr !== PW'(126) || get_ptr !== PW'(126) || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_preload: got sp=%0d gp=%0d empty=%b expected 126 126 1",
               store_ptr, get_ptr, empty);
    end
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, 1'b0, i >= 3, 1'b0, 1'b0);
      obs_v = obs(); exp_vv = exp_v(); vectors++;
      if (obs_v !== exp_vv) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got %s expected %s", i, fmt(obs_v), fmt(exp_vv));
      end
    end
    vectors++;
    if (store_ptr !== PW'(1) || get_ptr !== PW'(1)) begin
      miscompares++;
      $display("FAIL wrap_end: got sp=%0d gp=%0d expected 1 1", store_ptr, get_ptr);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (store_ptr !== PW'(1) || buffer_occupancy !== PW'(1)) begin
      miscompares++;
      $display("FAIL dual_store: got sp=%0d occ=%0d expected 1 1", store_ptr, buffer_occupancy);
    end
    for (int i = 1; i < DEPTH; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    obs_v = obs(); exp_vv = exp_v(); vectors++;
    if (obs_v !== exp_vv || buffer_occupancy !== PW'(DEPTH) || overflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL store_get_full: got %s expected %s", fmt(obs_v), fmt(exp_vv));
    end
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    obs_v = obs(); exp_vv = exp_v(); vectors++;
    if (obs_v !== exp_vv || buffer_occupancy !== PW'(1) || underflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL store_get_empty: got %s expected %s", fmt(obs_v), fmt(exp_vv));
    end
  endtask

  task automatic test_clear();
    do_reset();
    // Underflow with a store leaves one byte and (in sticky builds) a set error.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    obs_v = obs(); exp_vv = exp_v(); vectors++;
    if (obs_v !== exp_vv || buffer_occupancy !== PW'(20)) begin
      miscompares++;
      $display("FAIL clear_pre: got %s expected %s", fmt(obs_v), fmt(exp_vv));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    obs_v = obs(); exp_vv = {PW'(0), PW'(0), PW'(0), 1'b0, 1'b1, 1'b0, 1'b0}; vectors++;
    if (obs_v !== exp_vv) begin
      miscompares++;
      $display("FAIL clear: got %s expected %s", fmt(obs_v), fmt(exp_vv));
    end
  endtask

  task automatic test_random();
    int p_store, p_get;
    do_reset();
    for (int ph = 0; ph < 8; ph++) begin
      case (ph % 4)
        0:       begin p_store = 90; p_get = 15; end
        1:       begin p_store = 50; p_get = 50; end
        2:       begin p_store = 10; p_get = 85; end
        default: begin p_store = 70; p_get = 65; end
      endcase
      for (int i = 0; i < 300; i++) begin
        logic s, g, which_s, which_g, clr;
        s       = ($urandom_range(99) < p_store);
        g       = ($urandom_range(99) < p_get);
        which_s = $urandom_range(2) == 0;
        which_g = $urandom_range(2) == 0;
        clr     = ($urandom_range(255) == 0);
        drive(s && (which_s || $urandom_range(1) == 0), s && !which_s,
              g && (which_g || $urandom_range(1) == 0), g && !which_g, clr);
        obs_v = obs(); exp_vv = exp_v(); vectors++;
        if (obs_v !== exp_vv) begin
          miscompares++;
          $display("FAIL random[%0d.%0d]: got %s expected %s", ph, i, fmt(obs_v), fmt(exp_vv));
        end
      end
    end
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0;
    st_tx = 1'b0; st_rx = 1'b0; g_rx = 1'b0; g_tx = 1'b0;
    model_reset();
    #12;
    obs_v = obs(); exp_vv = exp_v(); vectors++;
    if (obs_v !== exp_vv) begin
      miscompares++;
      $display("FAIL power_on_reset: got %s expected %s", fmt(obs_v), fmt(exp_vv));
    end
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
- Pointer and flag controller for the 64-entry endpoint data FIFO.
- Turns store/get strobes from the AHB-slave side and the USB RX/TX side into the 7-bit store_ptr/get_ptr that drive the FIFO RAM directly.
- Also produces buffer_occupancy, full/empty and overflow/underflow error flags.
- Sits directly upstream of the FIFO RAM; its pointer outputs are the RAM's address inputs.

Parameters:
- DEPTH, 64, number of FIFO entries; must be a power of two.
- ADDR_W, 6, log2(DEPTH). Pointers are ADDR_W+1 bits wide; the extra MSB is the wrap/lap bit.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous, active-low reset
- clear  input  1  synchronous flush of the FIFO (from the host "clear" register write)
- store_tx_data  input  1  AHB side writes one byte this cycle
- store_rx_packet_data  input  1  USB RX side writes one byte this cycle
- get_rx_data  input  1  AHB side consumes one byte this cycle
- get_tx_packet_data  input  1  USB TX side consumes one byte this cycle
- store_ptr  output  ADDR_W+1  write pointer to the RAM
- get_ptr  output  ADDR_W+1  read pointer to the RAM
- buffer_occupancy  output  ADDR_W+1  bytes held, 0..DEPTH
- full  output  1  occupancy == DEPTH
- empty  output  1  occupancy == 0
- overflow_err  output  1  store attempted while full
- underflow_err  output  1  get attempted while empty

Behaviour:
- Reset (async, n_rst=0): store_ptr=0, get_ptr=0, buffer_occupancy=0, full=0, empty=1, overflow_err=0, underflow_err=0.
- store_req = store_tx_data | store_rx_packet_data. If both are high, the FIFO advances by one entry only.
- get_req = get_rx_data | get_tx_packet_data, also counted once.
- All outputs are registered and update on the same rising edge as the accepted strobe (one-cycle latency).
- Invariant on every cycle: buffer_occupancy == store_ptr - get_ptr, computed modulo 2^(ADDR_W+1).
- Flag derivation:
  - empty when the pointers are fully equal.
  - full when the low ADDR_W bits are equal and the MSBs differ.
- Pointers increment modulo 2^(ADDR_W+1), so 127 wraps to 0 with no special handling.
- Priority and acceptance rules, evaluated each cycle:
  - clear=1: both pointers go to 0, occupancy 0, empty=1, full=0, both error flags cleared. All strobes in that cycle are ignored.
  - store_req while not full: store_ptr+1.
  - store_req while full and no get_req: store rejected; pointer held; overflow_err set.
  - store_req and get_req while full: both accepted; occupancy stays DEPTH.
  - get_req while not empty: get_ptr+1.
  - get_req while empty: get rejected; underflow_err set. A simultaneous store is still accepted, giving occupancy 1 next cycle.
  - store_req and get_req while neither full nor empty: both pointers advance; occupancy unchanged.
- RAM corruption from a rejected store is outside this block; it only reports the error.
- An n_rst assertion mid-operation overrides everything immediately and returns the reset values.

Optional Feature:
- Macro FIFO_ERR_STICKY_EN.
- Defined: overflow_err/underflow_err are sticky. They stay high from the offending cycle until clear=1 or reset.
- Undefined: each error flag is a single-cycle pulse, high only on the edge following the rejected strobe.
- Pointer and occupancy behaviour is identical in both builds.

Test Plan:
- Reset: drive n_rst=0 mid-run -> store_ptr=0, get_ptr=0, occupancy=0, empty=1, full=0, errors=0 immediately.
- Fill: 64 cycles of store_tx_data=1 -> store_ptr=64, occupancy=64, full=1, empty=0. 65th store -> store_ptr stays 64, overflow_err=1 (sticky, or 1-cycle pulse without the macro).
- Drain: 64 get_rx_data from full -> get_ptr=64, occupancy=0, empty=1. Extra get -> underflow_err=1, get_ptr stays 64.
- Wrap-around: preload store_ptr=get_ptr=126, then 3 stores and 3 gets -> pointers reach 1. Occupancy matches store_ptr-get_ptr mod 128 on every cycle, including the 127->0 step.
- Simultaneous strobes:
  - store_tx_data and store_rx_packet_data together -> +1 only.
  - store+get at full -> both accepted, occupancy stays 64, no error.
  - store+get at empty -> underflow_err=1, occupancy 1.
- Clear: with occupancy 20 and errors set, pulse clear together with store_tx_data -> next cycle both pointers 0, occupancy 0, errors 0, and the store is ignored.
